// File: rtl/back_end_native.sv
// ---------------------------------------------------------------------------
// back_end_native
//
// Memory-side initiator of the cache's native valid/ready interface.
// Drains write-through buffer entries to memory (one word per transaction)
// and refills a cache line as a burst of word reads on a miss. Buffered
// writes always win over a pending refill, so a refill never reads a
// location that still has a newer value waiting in the write buffer.
//
// Optional feature macro: BE_WORD_ADDR_EN
//   defined   : mem_addr is a word address, FE_ADDR_W-FE_BYTE_W bits wide
//   undefined : mem_addr is a byte address, FE_ADDR_W bits wide, low
//               FE_BYTE_W bits always zero
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   write_valid       write buffer holds an entry
//   write_addr/wdata/wstrb  head entry of the write buffer (word address)
//   write_pop         1-cycle pulse: head entry accepted by memory
//   replace_valid     refill request (level, held until replace is seen)
//   replace_addr      line address to refill
//   replace           refill in progress
//   read_valid        refill word valid this cycle
//   read_addr         word index within the line
//   read_rdata        refill word
//   mem_valid         memory request
//   mem_addr          memory address (byte or word, see macro above)
//   mem_wdata         write data
//   mem_wstrb         byte strobes; all zero means read
//   mem_rdata         read data, valid together with mem_ready
//   mem_ready         request accepted/completed this cycle
// ---------------------------------------------------------------------------
module back_end_native #(
  parameter int unsigned FE_ADDR_W  = 32,
  parameter int unsigned FE_DATA_W  = 32,
  parameter int unsigned WORD_OFF_W = 2,
  localparam int unsigned FE_NBYTES = FE_DATA_W / 8,
  localparam int unsigned FE_BYTE_W = $clog2(FE_NBYTES),
  localparam int unsigned RD_ADDR_W = (WORD_OFF_W > 0) ? WORD_OFF_W : 1,
`ifdef BE_WORD_ADDR_EN
  localparam int unsigned MEM_ADDR_W = FE_ADDR_W - FE_BYTE_W
`else
  localparam int unsigned MEM_ADDR_W = FE_ADDR_W
`endif
) (
  input  logic                                    clk,
  input  logic                                    reset,
  // write-through buffer side
  input  logic                                    write_valid,
  input  logic [FE_ADDR_W-FE_BYTE_W-1:0]          write_addr,
  input  logic [FE_DATA_W-1:0]                    write_wdata,
  input  logic [FE_NBYTES-1:0]                    write_wstrb,
  output logic                                    write_pop,
  // line refill side
  input  logic                                    replace_valid,
  input  logic [FE_ADDR_W-FE_BYTE_W-WORD_OFF_W-1:0] replace_addr,
  output logic                                    replace,
  output logic                                    read_valid,
  output logic [RD_ADDR_W-1:0]                    read_addr,
  output logic [FE_DATA_W-1:0]                    read_rdata,
  // memory side
  output logic                                    mem_valid,
  output logic [MEM_ADDR_W-1:0]                   mem_addr,
  output logic [FE_DATA_W-1:0]                    mem_wdata,
  output logic [FE_NBYTES-1:0]                    mem_wstrb,
  input  logic [FE_DATA_W-1:0]                    mem_rdata,
  input  logic                                    mem_ready
);

  localparam int unsigned WA_W = FE_ADDR_W - FE_BYTE_W;   // word address width
  localparam int unsigned LA_W = WA_W - WORD_OFF_W;        // line address width
  localparam logic [RD_ADDR_W-1:0] LAST_WORD = RD_ADDR_W'((1 << WORD_OFF_W) - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_e;

  state_e               state_q, state_d;
  logic [RD_ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [LA_W-1:0]      line_addr_q, line_addr_d;
  logic [WA_W-1:0]      rd_word_addr;

  // Line address is captured when the refill starts: the controller drops
  // replace_valid once it sees replace, so the request inputs are not
  // guaranteed to stay put for the whole burst, while mem_addr must.
  if (WORD_OFF_W > 0) begin : g_multi_word
    assign rd_word_addr = {line_addr_q, word_cnt_q[RD_ADDR_W-1:0]};
  end else begin : g_single_word
    assign rd_word_addr = line_addr_q;
  end

  function automatic logic [MEM_ADDR_W-1:0] to_mem_addr(input logic [WA_W-1:0] wa);
`ifdef BE_WORD_ADDR_EN
    return wa;
`else
    return MEM_ADDR_W'(wa) << FE_BYTE_W;
`endif
  endfunction

  // Next state and all outputs. Every output is a function of the
  // registered state (plus mem_ready/mem_rdata for the completion strobes),
  // so the asynchronous reset forces all outputs low immediately.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    line_addr_d = line_addr_q;

    write_pop   = 1'b0;
    replace     = 1'b0;
    read_valid  = 1'b0;
    read_addr   = '0;
    read_rdata  = '0;
    mem_valid   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;

    case (state_q)
      ST_IDLE: begin
        if (write_valid) begin
          state_d = ST_WRITE;
        end else if (replace_valid) begin
          state_d     = ST_READ;
          line_addr_d = replace_addr;
          word_cnt_d  = '0;
        end
      end

      ST_WRITE: begin
        mem_valid = 1'b1;
        mem_addr  = to_mem_addr(write_addr);
        mem_wdata = write_wdata;
        mem_wstrb = write_wstrb;
        if (mem_ready) begin
          write_pop = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_READ: begin
        replace   = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = to_mem_addr(rd_word_addr);
        if (mem_ready) begin
          read_valid = 1'b1;
          read_addr  = word_cnt_q;
          read_rdata = mem_rdata;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            word_cnt_d = word_cnt_q + RD_ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      line_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      line_addr_q <= line_addr_d;
    end
  end

endmodule

// File: tb/tb_back_end_native.sv
// ---------------------------------------------------------------------------
// tb_back_end_native
//
// Bench for back_end_native with FE_ADDR_W=32, FE_DATA_W=32, WORD_OFF_W=2.
// A table of write/refill records (stimulus plus expected first-beat memory
// address) is applied in a loop; every expected memory beat is queued when
// the stimulus is driven and checked against the DUT while it is presented
// and when it completes. Hand-written sequences cover write/refill priority,
// writes arriving during a refill, and reset in the middle of transactions.
// Honours BE_WORD_ADDR_EN for the expected address form.
// ---------------------------------------------------------------------------
module tb_back_end_native;

  localparam int unsigned FE_ADDR_W  = 32;
  localparam int unsigned FE_DATA_W  = 32;
  localparam int unsigned WORD_OFF_W = 2;
`ifdef BE_WORD_ADDR_EN
  localparam int unsigned MAW = 30;
`else
  localparam int unsigned MAW = 32;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             write_valid = 1'b0;
  logic [29:0]      write_addr = '0;
  logic [31:0]      write_wdata = '0;
  logic [3:0]       write_wstrb = '0;
  logic             write_pop;
  logic             replace_valid = 1'b0;
  logic [27:0]      replace_addr = '0;
  logic             replace;
  logic             read_valid;
  logic [1:0]       read_addr;
  logic [31:0]      read_rdata;
  logic             mem_valid;
  logic [MAW-1:0]   mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [31:0]      mem_rdata;
  logic             mem_ready = 1'b0;

  back_end_native #(
    .FE_ADDR_W (FE_ADDR_W),
    .FE_DATA_W (FE_DATA_W),
    .WORD_OFF_W(WORD_OFF_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_valid  (write_valid),
    .write_addr   (write_addr),
    .write_wdata  (write_wdata),
    .write_wstrb  (write_wstrb),
    .write_pop    (write_pop),
    .replace_valid(replace_valid),
    .replace_addr (replace_addr),
    .replace      (replace),
    .read_valid   (read_valid),
    .read_addr    (read_addr),
    .read_rdata   (read_rdata),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_model(input logic [29:0] wa);
    return 32'hA0A0_0000 ^ {2'b00, wa} ^ {wa[7:0], 24'h0};
  endfunction

  function automatic logic [29:0] to_wa(input logic [MAW-1:0] a);
`ifdef BE_WORD_ADDR_EN
    return a;
`else
    return a[31:2];
`endif
  endfunction

  // expected memory address from a byte address
  function automatic logic [MAW-1:0] exp_mem(input logic [31:0] b);
`ifdef BE_WORD_ADDR_EN
    return b[31:2];
`else
    return b;
`endif
  endfunction

  assign mem_rdata = mem_model(to_wa(mem_addr));

  int unsigned fixed_gap = 0;
  bit          rand_gap  = 1'b0;

  // Responder: per beat waits a gap of idle cycles, then pulses mem_ready.
  // While nothing is requested it drives random ready, which must be ignored.
  initial begin : responder
    bit          pending;
    int unsigned left;
    pending = 1'b0;
    left    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid) begin
        if (!pending) begin
          pending = 1'b1;
          left    = rand_gap ? $urandom_range(0, 3) : fixed_gap;
        end
        if (left == 0) begin
          mem_ready = 1'b1;
          pending   = 1'b0;
        end else begin
          mem_ready = 1'b0;
          left--;
        end
      end else begin
        pending   = 1'b0;
        mem_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit             is_rd;
    logic [MAW-1:0] addr;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic [1:0]     ridx;
    logic [31:0]    rdata;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({write_pop, replace, read_valid, read_addr, read_rdata,
                 mem_valid, mem_addr, mem_wdata, mem_wstrb});
  endfunction

  initial begin : monitor
    exp_t h;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("outs_in_reset", outs(), '0);
      end else if (mem_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_req: got mem_addr 0x%0h, want no request (t=%0t)", mem_addr, $time);
        end else begin
          h = exp_q[0];
          chk("mem_addr",  128'(mem_addr),  128'(h.addr));
          chk("mem_wdata", 128'(mem_wdata), 128'(h.wdata));
          chk("mem_wstrb", 128'(mem_wstrb), 128'(h.wstrb));
          chk("replace",   128'(replace),   128'(h.is_rd));
          if (mem_ready) begin
            chk("write_pop",  128'(write_pop),  128'(!h.is_rd));
            chk("read_valid", 128'(read_valid), 128'(h.is_rd));
            if (h.is_rd) begin
              chk("read_addr",  128'(read_addr),  128'(h.ridx));
              chk("read_rdata", 128'(read_rdata), 128'(h.rdata));
            end
            void'(exp_q.pop_front());
          end else begin
            chk("strobes_during_wait", 128'({write_pop, read_valid}), '0);
          end
        end
      end else begin
        chk("idle_outs", outs(), '0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    bit          is_wr;
    logic [29:0] addr;      // word address (write) or line address (refill)
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned gap;
    bit          rnd;
    logic [31:0] exp_base;  // expected byte address of the first beat
  } vec_t;

  // sel: 0 write_pop high, 1 replace high, 2 replace low
  task automatic wait_sig(input string name, input int sel, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((sel == 0 && write_pop) || (sel == 1 && replace) || (sel == 2 && !replace)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout_%s: got no event, want it within %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input vec_t v);
    exp_t e;
    e.is_rd = 1'b0;
    e.addr  = exp_mem(v.exp_base);
    e.wdata = v.wdata;
    e.wstrb = v.wstrb;
    e.ridx  = '0;
    e.rdata = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_refill(input logic [31:0] base);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.is_rd = 1'b1;
      e.addr  = exp_mem(base + 32'(4 * i));
      e.wdata = '0;
      e.wstrb = '0;
      e.ridx  = 2'(i);
      e.rdata = mem_model(to_wa(e.addr));
      exp_q.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v);
    fixed_gap = v.gap;
    rand_gap  = v.rnd;
    if (v.is_wr) begin
      push_write(v);
      write_addr  = v.addr;
      write_wdata = v.wdata;
      write_wstrb = v.wstrb;
      write_valid = 1'b1;
      wait_sig("write_pop", 0, 64);
      write_valid = 1'b0;
    end else begin
      push_refill(v.exp_base);
      replace_addr  = v.addr[27:0];
      replace_valid = 1'b1;
      wait_sig("replace_rise", 1, 64);
      replace_valid = 1'b0;
      wait_sig("replace_fall", 2, 128);
    end
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[8];

  initial begin : main
    vec_t v;

    vecs[0] = '{1'b1, 30'h100,        32'hDEAD_BEEF, 4'hF, 3, 1'b0, 32'h0000_0400};
    vecs[1] = '{1'b0, 30'h10,         32'h0,         4'h0, 0, 1'b0, 32'h0000_0100};
    vecs[2] = '{1'b1, 30'h3FFF_FFFF,  32'h1234_5678, 4'h1, 0, 1'b0, 32'hFFFF_FFFC};
    vecs[3] = '{1'b0, 30'h0FFF_FFFF,  32'h0,         4'h0, 0, 1'b0, 32'hFFFF_FFF0};
    vecs[4] = '{1'b1, 30'h0,          32'hA5A5_A5A5, 4'h6, 1, 1'b0, 32'h0000_0000};
    vecs[5] = '{1'b0, 30'h0,          32'h0,         4'h0, 0, 1'b1, 32'h0000_0000};
    vecs[6] = '{1'b0, 30'h0123_4567,  32'h0,         4'h0, 0, 1'b1, 32'h1234_5670};
    vecs[7] = '{1'b1, 30'h2AAA_AAAA,  32'h0F0F_0F0F, 4'h8, 0, 1'b1, 32'hAAAA_AAA8};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      chk("drained_after_vec", 128'(exp_q.size()), '0);
    end

    // write and refill requested together: write first, then the refill
    fixed_gap = 0;
    rand_gap  = 1'b0;
    v = '{1'b1, 30'h0000_0ABC, 32'hCAFE_F00D, 4'hC, 0, 1'b0, 32'h0000_2AF0};
    push_write(v);
    push_refill(32'h0000_0550);
    write_addr    = v.addr;
    write_wdata   = v.wdata;
    write_wstrb   = v.wstrb;
    replace_addr  = 28'h55;
    write_valid   = 1'b1;
    replace_valid = 1'b1;
    wait_sig("prio_write_pop", 0, 64);
    write_valid = 1'b0;
    wait_sig("prio_replace_rise", 1, 64);
    replace_valid = 1'b0;
    wait_sig("prio_replace_fall", 2, 128);
    chk("drained_after_prio", 128'(exp_q.size()), '0);

    // write arriving during a refill waits until the burst is done
    rand_gap = 1'b1;
    push_refill(32'h0000_7770);
    v = '{1'b1, 30'h0000_1111, 32'h5555_AAAA, 4'h3, 0, 1'b0, 32'h0000_4444};
    push_write(v);
    replace_addr  = 28'h777;
    replace_valid = 1'b1;
    wait_sig("nopre_replace_rise", 1, 64);
    replace_valid = 1'b0;
    write_addr    = v.addr;
    write_wdata   = v.wdata;
    write_wstrb   = v.wstrb;
    write_valid   = 1'b1;
    wait_sig("nopre_write_pop", 0, 128);
    write_valid = 1'b0;
    chk("drained_after_nopre", 128'(exp_q.size()), '0);

    // reset in the middle of a slow write
    rand_gap  = 1'b0;
    fixed_gap = 10;
    v = '{1'b1, 30'h0000_0200, 32'h1111_2222, 4'hF, 10, 1'b0, 32'h0000_0800};
    push_write(v);
    write_addr  = v.addr;
    write_wdata = v.wdata;
    write_wstrb = v.wstrb;
    write_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mem_valid_before_reset", 128'(mem_valid), 128'(1));
    reset = 1'b1;
    exp_q.delete();
    write_valid = 1'b0;
    #1;
    chk("outs_at_reset_write", outs(), '0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    fixed_gap = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mem_valid_after_reset", 128'(mem_valid), '0);
    end
    @(posedge clk);
    #1;

    // reset after two refill words, then a fresh refill restarts at word 0
    push_refill(32'h0000_0AA0);
    replace_addr  = 28'hAA;
    replace_valid = 1'b1;
    wait_sig("rst_replace_rise", 1, 64);
    replace_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("replace_before_reset", 128'(replace), 128'(1));
    chk("beats_left_before_reset", 128'(exp_q.size()), 128'(2));
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("outs_at_reset_refill", outs(), '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_vec('{1'b0, 30'h20, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0200});
    chk("drained_after_restart", 128'(exp_q.size()), '0);

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", 128'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
